mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access pipeline stage sitting directly upstream of the write-back stage of the image-filter processor.
- Takes execute-stage results, performs the word or pixel-byte data-memory access through a req/ack handshake, and stalls execute while the access is outstanding.
- Registers the load data, ALU result, pixel byte, destination register and data-select into the write-back stage's inputs.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in BUSY before an access is aborted (used only when MEM_TIMEOUT_EN is defined).
- RG_W, 4, destination register index width.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- ex_valid  in  1  Execute stage presents a valid op.
- ex_ready  out  1  Stage accepts the op this cycle.
- ex_alu_result  in  32  ALU result; also the memory address for loads/stores.
- ex_store_data  in  32  Store data.
- ex_rg  in  RG_W  Destination register.
- ex_mem_rd  in  1  Op is a load.
- ex_mem_wr  in  1  Op is a store.
- ex_byte  in  1  Pixel (8-bit) access; 0 = word access.
- ex_reg_we  in  1  Op writes the register file.
- flush  in  1  Squash the op in flight or being accepted.
- dmem_req  out  1  Memory request.
- dmem_we  out  1  Write enable.
- dmem_byte  out  1  Byte access.
- dmem_addr  out  32  Access address.
- dmem_wdata  out  32  Write data.
- dmem_ack  in  1  Access complete; dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  Read data.
- wb_valid  out  1  Write-back inputs valid.
- wb_do  out  32  Load data to write-back (Do).
- wb_alu_result  out  32  ALU result to write-back.
- wb_dob  out  8  Pixel byte to write-back (Dob_In).
- wb_rg  out  RG_W  Destination register to write-back (Rg_In).
- wb_sel_dat  out  1  1 = write back wb_do, 0 = write back wb_alu_result.
- wb_reg_we  out  1  Register-file write enable.
- mem_err  out  1  One-cycle pulse on access timeout.

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset is asynchronous and takes effect mid-access: dmem_req drops immediately and any pending result is discarded.
- FSM states: IDLE, BUSY.
- ex_ready is 1 in IDLE and 0 in BUSY.
- Accept condition: ex_valid && ex_ready && !flush. A flushed op is dropped and produces no wb_valid.
- Non-memory op accepted in IDLE:
  - Next cycle: wb_valid=1, wb_alu_result=ex_alu_result, wb_sel_dat=0, wb_do=0, wb_dob=0, wb_rg/wb_reg_we copied.
  - FSM stays in IDLE. Latency is 1 cycle.
- Memory op accepted in IDLE:
  - Latch address, data, byte flag, rg and reg_we; go to BUSY. wb_valid=0 next cycle.
  - dmem_req=1 from the first BUSY cycle and held until dmem_ack.
  - dmem_addr, dmem_we, dmem_byte and dmem_wdata are held stable while dmem_req=1.
- Address alignment: word access drives dmem_addr = {addr[31:2],2'b00}; byte access drives the full address.
- Byte store data: dmem_wdata = store_data[7:0] replicated into all 4 lanes.
- dmem_ack in BUSY: next cycle wb_valid=1, FSM returns to IDLE, dmem_req=0.
  - Load: wb_do=dmem_rdata, wb_sel_dat=1.
  - Load, byte access: wb_dob = rdata byte lane addr[1:0] (lane 0 = bits 7:0); wb_do = that byte zero-extended.
  - Load, word access: wb_dob=rdata[7:0].
  - Store: wb_sel_dat=0, wb_reg_we=0, wb_dob=store_data[7:0].
- Minimum memory-op latency: accept -> wb_valid is 2 cycles, plus one cycle per ack wait.
- Op with both ex_mem_rd and ex_mem_wr set is treated as a store.
- dmem_ack in IDLE is ignored.
- flush while BUSY: the bus access still completes (no abort). The result is emitted with wb_valid=1 and wb_reg_we=0.
- wb_valid is a single-cycle pulse per op. Write-back never back-pressures.
- Back-to-back: a new op may be accepted in the same cycle wb_valid is high (FSM back in IDLE).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, dmem_req drops, FSM returns to IDLE, and the next cycle has wb_valid=1, wb_reg_we=0, wb_do=0, mem_err=1 for one cycle.
  - An ack arriving in the same cycle as expiry wins: normal completion, no mem_err.
- When undefined: no counter, mem_err tied 0, BUSY waits indefinitely.

Decomposition:
- Shared package `proc_pkg` holds:
  - FSM state enum (IDLE/BUSY).
  - Constants DATA_W=32, PIX_W=8, RG_W default.
  - TIMEOUT_CYCLES default.
- One natural sub-module, `byte_lane_sel`: combinational extraction of an 8-bit lane from a 32-bit word by addr[1:0], reused by the write-back pixel path.

Test Plan:
- ALU op ex_alu_result=0x12345678, rg=3, reg_we=1, no mem -> 1 cycle later wb_valid=1, wb_alu_result=0x12345678, wb_sel_dat=0, wb_rg=3; ex_ready stays 1.
- Word load addr=0x00000106, dmem_ack 3 cycles after req with rdata=0xAABBCCDD -> dmem_addr=0x00000104 held throughout; ex_ready=0 during BUSY; then wb_do=0xAABBCCDD, wb_sel_dat=1, wb_dob=0xDD.
- Byte load addr=0x00000202, rdata=0x11223344 -> wb_dob=0x22, wb_do=0x00000022.
- Byte store addr=0x10, data=0x000000A5 -> dmem_we=1, dmem_byte=1, dmem_wdata=0xA5A5A5A5; after ack wb_reg_we=0, wb_dob=0xA5.
- flush during BUSY, then ack -> wb_valid=1 with wb_reg_we=0. rst_n low mid-BUSY -> dmem_req=0 immediately and no wb_valid after release.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 BUSY cycles; mem_err pulse and wb_valid=1 with wb_reg_we=0, wb_do=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the image-filter processor pipeline: data widths,
// default parameter values, the memory-access FSM state type and small
// address/data helpers.
package proc_pkg;

   localparam int unsigned DATA_W                 = 32;
   localparam int unsigned PIX_W                  = 8;
   localparam int unsigned RG_W_DEFAULT           = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
   localparam int unsigned TMO_CNT_W              = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mas_state_e;

   // Word accesses ignore the two byte-offset bits of the address.
   function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
      return {addr[DATA_W-1:2], 2'b00};
   endfunction

   // A pixel store places its byte on every lane so memory can pick any lane.
   function automatic logic [DATA_W-1:0] byte_splat(input logic [PIX_W-1:0] pix);
      return {4{pix}};
   endfunction

endpackage

// File: rtl/byte_lane_sel.sv
// Combinational extraction of one 8-bit lane from a 32-bit word.
// Lane 0 is bits 7:0, lane 3 is bits 31:24.
module byte_lane_sel
   import proc_pkg::*;
(
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        lane_i,
   output logic [PIX_W-1:0]  byte_o
);

   // Select the addressed byte lane.
   always_comb begin
      byte_o = word_i[7:0];
      case (lane_i)
         2'd0:    byte_o = word_i[7:0];
         2'd1:    byte_o = word_i[15:8];
         2'd2:    byte_o = word_i[23:16];
         2'd3:    byte_o = word_i[31:24];
         default: byte_o = word_i[7:0];
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Accepts execute results, performs word or
// pixel-byte data-memory accesses over a req/ack handshake while stalling
// execute, and registers the results into the write-back stage inputs.
// Optional build macro MEM_TIMEOUT_EN: abort an access that waits
// TIMEOUT_CYCLES BUSY cycles without ack and pulse mem_err.
module mem_access_stage
   import proc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned RG_W           = RG_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [RG_W-1:0]   ex_rg,
   input  logic              ex_mem_rd,
   input  logic              ex_mem_wr,
   input  logic              ex_byte,
   input  logic              ex_reg_we,
   input  logic              flush,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic              dmem_byte,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_do,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [PIX_W-1:0]  wb_dob,
   output logic [RG_W-1:0]   wb_rg,
   output logic              wb_sel_dat,
   output logic              wb_reg_we,
   output logic              mem_err
);

   mas_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic              byte_q, byte_d;
   logic [DATA_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] op_alu_q, op_alu_d;
   logic [RG_W-1:0]   op_rg_q, op_rg_d;
   logic              op_reg_we_q, op_reg_we_d;
   logic              kill_q, kill_d;

   logic              wb_valid_q, wb_valid_d;
   logic [DATA_W-1:0] wb_do_q, wb_do_d;
   logic [DATA_W-1:0] wb_alu_q, wb_alu_d;
   logic [PIX_W-1:0]  wb_dob_q, wb_dob_d;
   logic [RG_W-1:0]   wb_rg_q, wb_rg_d;
   logic              wb_sel_q, wb_sel_d;
   logic              wb_reg_we_q, wb_reg_we_d;

   logic              accept_s;
   logic              is_mem_s;
   logic              timeout_s;
   logic [1:0]        lane_s;
   logic [PIX_W-1:0]  lane_byte_s;

   assign ex_ready = (state_q == ST_IDLE);
   assign accept_s = ex_valid && ex_ready && !flush;
   assign is_mem_s = ex_mem_rd || ex_mem_wr;

   // Word loads return the low byte as the pixel; byte loads use the address lane.
   assign lane_s = byte_q ? op_alu_q[1:0] : 2'b00;

   byte_lane_sel u_lane_sel (
      .word_i (dmem_rdata),
      .lane_i (lane_s),
      .byte_o (lane_byte_s)
   );

`ifdef MEM_TIMEOUT_EN
   logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                 mem_err_q, mem_err_d;

   // Count BUSY cycles without ack; held at zero outside BUSY so each access starts fresh.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == ST_IDLE) begin
         tmo_cnt_d = {TMO_CNT_W{1'b0}};
      end else if (!dmem_ack) begin
         tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
      end else begin
         tmo_cnt_d = tmo_cnt_q;
      end
      timeout_s = (state_q == ST_BUSY) && !dmem_ack &&
                  (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
      mem_err_d = timeout_s;
   end

   // Timeout counter and error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= {TMO_CNT_W{1'b0}};
         mem_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;
`else
   assign timeout_s = 1'b0;
   assign mem_err   = 1'b0;
`endif

   // Next-state and next-output computation for the IDLE/BUSY access FSM.
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      we_d        = we_q;
      byte_d      = byte_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      op_alu_d    = op_alu_q;
      op_rg_d     = op_rg_q;
      op_reg_we_d = op_reg_we_q;
      kill_d      = kill_q;
      wb_valid_d  = 1'b0;
      wb_do_d     = wb_do_q;
      wb_alu_d    = wb_alu_q;
      wb_dob_d    = wb_dob_q;
      wb_rg_d     = wb_rg_q;
      wb_sel_d    = wb_sel_q;
      wb_reg_we_d = wb_reg_we_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_s && is_mem_s) begin
               state_d     = ST_BUSY;
               req_d       = 1'b1;
               we_d        = ex_mem_wr;
               byte_d      = ex_byte;
               addr_d      = ex_byte ? ex_alu_result : word_align(ex_alu_result);
               wdata_d     = ex_byte ? byte_splat(ex_store_data[PIX_W-1:0]) : ex_store_data;
               op_alu_d    = ex_alu_result;
               op_rg_d     = ex_rg;
               op_reg_we_d = ex_reg_we;
               kill_d      = 1'b0;
            end else if (accept_s) begin
               wb_valid_d  = 1'b1;
               wb_alu_d    = ex_alu_result;
               wb_sel_d    = 1'b0;
               wb_do_d     = {DATA_W{1'b0}};
               wb_dob_d    = {PIX_W{1'b0}};
               wb_rg_d     = ex_rg;
               wb_reg_we_d = ex_reg_we;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (dmem_ack) begin
               state_d    = ST_IDLE;
               req_d      = 1'b0;
               wb_valid_d = 1'b1;
               wb_alu_d   = op_alu_q;
               wb_rg_d    = op_rg_q;
               if (we_q) begin
                  wb_sel_d    = 1'b0;
                  wb_reg_we_d = 1'b0;
                  wb_do_d     = {DATA_W{1'b0}};
                  wb_dob_d    = wdata_q[PIX_W-1:0];
               end else begin
                  wb_sel_d    = 1'b1;
                  wb_reg_we_d = op_reg_we_q && !kill_q && !flush;
                  wb_do_d     = byte_q ? {{(DATA_W-PIX_W){1'b0}}, lane_byte_s} : dmem_rdata;
                  wb_dob_d    = lane_byte_s;
               end
            end else if (timeout_s) begin
               state_d     = ST_IDLE;
               req_d       = 1'b0;
               wb_valid_d  = 1'b1;
               wb_alu_d    = op_alu_q;
               wb_rg_d     = op_rg_q;
               wb_sel_d    = 1'b0;
               wb_reg_we_d = 1'b0;
               wb_do_d     = {DATA_W{1'b0}};
               wb_dob_d    = {PIX_W{1'b0}};
            end else begin
               kill_d = kill_q || flush;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State, bus-side and write-back registers; async reset aborts any access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         byte_q      <= 1'b0;
         addr_q      <= {DATA_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         op_alu_q    <= {DATA_W{1'b0}};
         op_rg_q     <= {RG_W{1'b0}};
         op_reg_we_q <= 1'b0;
         kill_q      <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_do_q     <= {DATA_W{1'b0}};
         wb_alu_q    <= {DATA_W{1'b0}};
         wb_dob_q    <= {PIX_W{1'b0}};
         wb_rg_q     <= {RG_W{1'b0}};
         wb_sel_q    <= 1'b0;
         wb_reg_we_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         byte_q      <= byte_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         op_alu_q    <= op_alu_d;
         op_rg_q     <= op_rg_d;
         op_reg_we_q <= op_reg_we_d;
         kill_q      <= kill_d;
         wb_valid_q  <= wb_valid_d;
         wb_do_q     <= wb_do_d;
         wb_alu_q    <= wb_alu_d;
         wb_dob_q    <= wb_dob_d;
         wb_rg_q     <= wb_rg_d;
         wb_sel_q    <= wb_sel_d;
         wb_reg_we_q <= wb_reg_we_d;
      end
   end

   assign dmem_req      = req_q;
   assign dmem_we       = we_q;
   assign dmem_byte     = byte_q;
   assign dmem_addr     = addr_q;
   assign dmem_wdata    = wdata_q;
   assign wb_valid      = wb_valid_q;
   assign wb_do         = wb_do_q;
   assign wb_alu_result = wb_alu_q;
   assign wb_dob        = wb_dob_q;
   assign wb_rg         = wb_rg_q;
   assign wb_sel_dat    = wb_sel_q;
   assign wb_reg_we     = wb_reg_we_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the stage.
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO = 255;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_ready;
   logic [31:0] ex_alu_result, ex_store_data;
   logic [3:0]  ex_rg;
   logic        ex_mem_rd, ex_mem_wr, ex_byte, ex_reg_we, flush;
   logic        dmem_req, dmem_we, dmem_byte;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] wb_do, wb_alu_result;
   logic [7:0]  wb_dob;
   logic [3:0]  wb_rg;
   logic        wb_sel_dat, wb_reg_we, mem_err;

   int vectors = 0;
   int miscompares = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(TO), .RG_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_rg(ex_rg), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_byte(ex_byte), .ex_reg_we(ex_reg_we), .flush(flush),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_byte(dmem_byte),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_do(wb_do), .wb_alu_result(wb_alu_result),
      .wb_dob(wb_dob), .wb_rg(wb_rg), .wb_sel_dat(wb_sel_dat),
      .wb_reg_we(wb_reg_we), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_busy;
   int          m_cycles;
   logic [31:0] m_addr, m_data;
   logic [3:0]  m_rg;
   bit          m_byte, m_store, m_reg_we, m_killed;
   bit          e_valid, e_err, c_do, c_dob, c_sel;
   logic [31:0] e_alu, e_do;
   logic [7:0]  e_dob;
   logic [3:0]  e_rg;
   bit          e_sel, e_reg_we;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; e_valid = 1'b0; e_err = 1'b0;
   endtask

   // Outcome of one clock edge, from the inputs present at that edge.
   task automatic model_update();
      logic [31:0] lane;
      e_valid = 1'b0; e_err = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else if (!m_busy) begin
         if (ex_valid && !flush) begin
            if (ex_mem_rd || ex_mem_wr) begin
               m_busy = 1'b1; m_cycles = 0; m_killed = 1'b0;
               m_addr = ex_alu_result; m_data = ex_store_data; m_rg = ex_rg;
               m_byte = ex_byte; m_store = ex_mem_wr; m_reg_we = ex_reg_we;
            end else begin
               e_valid = 1'b1; e_alu = ex_alu_result; e_rg = ex_rg; e_reg_we = ex_reg_we;
               e_sel = 1'b0; e_do = 32'd0; e_dob = 8'd0;
               c_do = 1'b1; c_dob = 1'b1; c_sel = 1'b1;
            end
         end
      end else begin
         m_cycles++;
         if (flush) m_killed = 1'b1;
         if (dmem_ack) begin
            m_busy = 1'b0; e_valid = 1'b1; e_alu = m_addr; e_rg = m_rg; c_sel = 1'b1;
            if (m_store) begin
               e_sel = 1'b0; e_reg_we = 1'b0; e_dob = m_data[7:0];
               c_do = 1'b0; c_dob = 1'b1;
            end else begin
               lane = (dmem_rdata >> (8 * m_addr[1:0])) & 32'hFF;
               e_sel = 1'b1; e_reg_we = m_reg_we && !m_killed;
               e_do = m_byte ? lane : dmem_rdata;
               e_dob = m_byte ? lane[7:0] : dmem_rdata[7:0];
               c_do = 1'b1; c_dob = 1'b1;
            end
         end else if (TO_EN && m_cycles == TO) begin
            m_busy = 1'b0; e_valid = 1'b1; e_err = 1'b1; e_alu = m_addr; e_rg = m_rg;
            e_reg_we = 1'b0; e_do = 32'd0; c_do = 1'b1; c_dob = 1'b0; c_sel = 1'b0;
         end
      end
   endtask

   task automatic compare();
      chk("ex_ready", {31'd0, ex_ready}, {31'd0, !m_busy});
      chk("dmem_req", {31'd0, dmem_req}, {31'd0, m_busy});
      if (m_busy) begin
         chk("dmem_addr", dmem_addr, m_byte ? m_addr : (m_addr & 32'hFFFF_FFFC));
         chk("dmem_we", {31'd0, dmem_we}, {31'd0, m_store});
         chk("dmem_byte", {31'd0, dmem_byte}, {31'd0, m_byte});
         chk("dmem_wdata", dmem_wdata, m_byte ? (32'h0101_0101 * m_data[7:0]) : m_data);
      end
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_valid});
      if (e_valid) begin
         chk("wb_alu_result", wb_alu_result, e_alu);
         chk("wb_rg", {28'd0, wb_rg}, {28'd0, e_rg});
         chk("wb_reg_we", {31'd0, wb_reg_we}, {31'd0, e_reg_we});
         if (c_sel) chk("wb_sel_dat", {31'd0, wb_sel_dat}, {31'd0, e_sel});
         if (c_do)  chk("wb_do", wb_do, e_do);
         if (c_dob) chk("wb_dob", {24'd0, wb_dob}, {24'd0, e_dob});
      end
      chk("mem_err", {31'd0, mem_err}, {31'd0, e_err});
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic drive_idle();
      ex_valid = 1'b0; ex_alu_result = 32'd0; ex_store_data = 32'd0; ex_rg = 4'd0;
      ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_byte = 1'b0; ex_reg_we = 1'b0;
      flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
   endtask

   task automatic drive_op(input logic [31:0] alu, input logic [31:0] sd, input logic [3:0] rg,
                           input bit rd, input bit wr, input bit byt, input bit rwe);
      ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rg = rg;
      ex_mem_rd = rd; ex_mem_wr = wr; ex_byte = byt; ex_reg_we = rwe;
   endtask

   initial begin
      drive_idle();
      model_reset();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("rst wb_alu_result", wb_alu_result, 32'd0);
      chk("rst wb_do", wb_do, 32'd0);
      chk("rst mem_err", {31'd0, mem_err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // ALU op, one-cycle latency
      drive_op(32'h1234_5678, 32'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive_idle();
      chk("alu wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("alu wb_alu_result", wb_alu_result, 32'h1234_5678);
      chk("alu wb_sel_dat", {31'd0, wb_sel_dat}, 32'd0);
      chk("alu wb_rg", {28'd0, wb_rg}, 32'd3);
      chk("alu ex_ready", {31'd0, ex_ready}, 32'd1);
      tick();

      // Word load at unaligned address, ack on the fourth BUSY cycle
      drive_op(32'h0000_0106, 32'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         chk("wload dmem_addr", dmem_addr, 32'h0000_0104);
         chk("wload ex_ready", {31'd0, ex_ready}, 32'd0);
         chk("wload wb_valid", {31'd0, wb_valid}, 32'd0);
         tick();
      end
      chk("wload dmem_req", {31'd0, dmem_req}, 32'd1);
      dmem_ack = 1'b1; dmem_rdata = 32'hAABB_CCDD;
      tick();
      drive_idle();
      chk("wload wb_do", wb_do, 32'hAABB_CCDD);
      chk("wload wb_sel_dat", {31'd0, wb_sel_dat}, 32'd1);
      chk("wload wb_dob", {24'd0, wb_dob}, 32'h0000_00DD);
      tick();

      // Byte load, lane 2
      drive_op(32'h0000_0202, 32'd0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive_idle();
      dmem_ack = 1'b1; dmem_rdata = 32'h1122_3344;
      tick();
      drive_idle();
      chk("bload wb_dob", {24'd0, wb_dob}, 32'h0000_0022);
      chk("bload wb_do", wb_do, 32'h0000_0022);

      // Byte store
      drive_op(32'h0000_0010, 32'h0000_00A5, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      drive_idle();
      chk("bstore dmem_we", {31'd0, dmem_we}, 32'd1);
      chk("bstore dmem_byte", {31'd0, dmem_byte}, 32'd1);
      chk("bstore dmem_wdata", dmem_wdata, 32'hA5A5_A5A5);
      dmem_ack = 1'b1;
      tick();
      drive_idle();
      chk("bstore wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
      chk("bstore wb_dob", {24'd0, wb_dob}, 32'h0000_00A5);

      // Flush while BUSY: access completes, no register write
      drive_op(32'h0000_0040, 32'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive_idle();
      flush = 1'b1;
      tick();
      drive_idle();
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      tick();
      drive_idle();
      chk("flush wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("flush wb_reg_we", {31'd0, wb_reg_we}, 32'd0);

      // Async reset in the middle of an access
      drive_op(32'h0000_0080, 32'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive_idle();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst dmem_req", {31'd0, dmem_req}, 32'd0);
      tick();
      rst_n = 1'b1;
      dmem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("arst wb_valid", {31'd0, wb_valid}, 32'd0);
      end
      drive_idle();

`ifdef MEM_TIMEOUT_EN
      // Access never acknowledged: abort after TO BUSY cycles
      drive_op(32'h0000_0300, 32'd0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive_idle();
      for (int i = 0; i < 3; i++) tick();
      chk("tmo req before", {31'd0, dmem_req}, 32'd1);
      tick();
      chk("tmo dmem_req", {31'd0, dmem_req}, 32'd0);
      chk("tmo mem_err", {31'd0, mem_err}, 32'd1);
      chk("tmo wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("tmo wb_reg_we", {31'd0, wb_reg_we}, 32'd0);
      chk("tmo wb_do", wb_do, 32'd0);
      tick();
      chk("tmo mem_err pulse", {31'd0, mem_err}, 32'd0);
`endif

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         ex_valid = ($urandom_range(0, 99) < 55);
         ex_alu_result = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         ex_store_data = $urandom;
         ex_rg = 4'($urandom_range(0, 15));
         ex_mem_rd = 1'($urandom_range(0, 1));
         ex_mem_wr = 1'($urandom_range(0, 1));
         ex_byte = 1'($urandom_range(0, 1));
         ex_reg_we = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 99) < 10);
         dmem_ack = ($urandom_range(0, 99) < 35);
         dmem_rdata = $urandom;
         tick();
      end
      drive_idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
